// File: rtl/adder_pipe_pkg.sv
// Shared constants and segmentation helper for the segmented pipelined adder.
package adder_pipe_pkg;

    localparam int DEFAULT_WIDTH = 120;
    localparam int DEFAULT_SEG_W = 30;

    // Segment count and width of the final (possibly narrower) segment
    typedef struct packed {
        logic [31:0] nseg;
        logic [31:0] lastW;
    } segInfo_t;

    // Splits a WIDTH-bit add into ceil(WIDTH/SEG_W) segments; the top one takes the remainder
    function automatic segInfo_t calcSegInfo(input int width, input int segW);
        segInfo_t info;
        int       nseg;
        nseg       = (width + segW - 1) / segW;
        info.nseg  = 32'(nseg);
        info.lastW = 32'(width - (nseg - 1) * segW);
        return info;
    endfunction

endpackage

// File: rtl/adder_pipe_if.sv
// Operand/result stream bundle between a producer/consumer and the adder pipeline.
interface adder_pipe_if
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
    logic             ovf;

    // Producer/consumer side (testbench or upstream logic)
    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, ovf
    );

    // Adder side
    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, ovf
    );

endinterface

// File: rtl/adder_seg.sv
// One pipeline stage of the segmented adder: resolves bits [LO +: SW] using the
// carry registered by the previous stage and passes the operands along.
module adder_seg #(
    parameter int WIDTH = 8,
    parameter int LO    = 0,
    parameter int SW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance_i,
    input  logic             valid_i,
    input  logic             carry_i,
    input  logic [WIDTH-1:0] aOp_i,
    input  logic [WIDTH-1:0] bOp_i,
    input  logic [WIDTH-1:0] sum_i,
    output logic             valid_o,
    output logic             carry_o,
    output logic [WIDTH-1:0] aOp_o,
    output logic [WIDTH-1:0] bOp_o,
    output logic [WIDTH-1:0] sum_o
);

    logic [SW:0]      segRes_d;
    logic [WIDTH-1:0] sum_d;

    logic             valid_q;
    logic             carry_q;
    logic [WIDTH-1:0] aOp_q;
    logic [WIDTH-1:0] bOp_q;
    logic [WIDTH-1:0] sum_q;

    // Segment add; earlier stages only ever fill lower, disjoint bit ranges of the
    // partial sum, so OR-ing this segment in completes the same beat's result word
    always_comb begin
        segRes_d = {1'b0, aOp_i[LO +: SW]} + {1'b0, bOp_i[LO +: SW]} + {{SW{1'b0}}, carry_i};
        sum_d    = sum_i | (WIDTH'(segRes_d[SW-1:0]) << LO);
    end

    // Stage register: moves only on a global advance, and data only when a beat is present
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            aOp_q   <= '0;
            bOp_q   <= '0;
            sum_q   <= '0;
        end else if (advance_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                carry_q <= segRes_d[SW];
                aOp_q   <= aOp_i;
                bOp_q   <= bOp_i;
                sum_q   <= sum_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign carry_o = carry_q;
    assign aOp_o   = aOp_q;
    assign bOp_o   = bOp_q;
    assign sum_o   = sum_q;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract: stage 0 captures operands (b already inverted for
// subtract), then one carry segment resolves per stage. Latency is NSEG cycles,
// throughput one beat per cycle, and the whole pipe stalls together on
// backpressure. Expects WIDTH >= 2 and 1 <= SEG_W <= WIDTH.
module adder_pipe
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEG_W = DEFAULT_SEG_W
) (
    input  logic         clk,
    input  logic         rst_n,
    adder_pipe_if.slave  bus
);

    localparam segInfo_t SEG_INFO = calcSegInfo(WIDTH, SEG_W);
    localparam int       NSEG     = int'(SEG_INFO.nseg);
    localparam int       LAST_W   = int'(SEG_INFO.lastW);

    logic             advance;

    logic             valid0_q;
    logic [WIDTH-1:0] opA0_q;
    logic [WIDTH-1:0] opB0_q;
    logic [WIDTH-1:0] opB0_d;
    logic             cin0_q;
    logic             cin0_d;

    logic             stageValid [0:NSEG];
    logic             stageCarry [0:NSEG];
    logic [WIDTH-1:0] stageA     [0:NSEG];
    logic [WIDTH-1:0] stageB     [0:NSEG];
    logic [WIDTH-1:0] stageSum   [0:NSEG];

    // The pipe moves as a unit whenever the output slot is empty or being drained
    assign advance     = !stageValid[NSEG] || bus.out_ready;
    assign bus.in_ready = advance;

    // Subtract is a + ~b + !cin, so fold the inversion in before the first register
    always_comb begin
        opB0_d = bus.sub ? ~bus.b : bus.b;
        cin0_d = bus.sub ? !bus.cin : bus.cin;
    end

    // Operand capture stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid0_q <= 1'b0;
            opA0_q   <= '0;
            opB0_q   <= '0;
            cin0_q   <= 1'b0;
        end else if (advance) begin
            valid0_q <= bus.in_valid;
            if (bus.in_valid) begin
                opA0_q <= bus.a;
                opB0_q <= opB0_d;
                cin0_q <= cin0_d;
            end
        end
    end

    assign stageValid[0] = valid0_q;
    assign stageCarry[0] = cin0_q;
    assign stageA[0]     = opA0_q;
    assign stageB[0]     = opB0_q;
    assign stageSum[0]   = '0;

    for (genvar s = 0; s < NSEG; s++) begin : gSeg
        localparam int SEG_LO   = s * SEG_W;
        localparam int SEG_SIZE = (s == NSEG - 1) ? LAST_W : SEG_W;

        adder_seg #(
            .WIDTH (WIDTH),
            .LO    (SEG_LO),
            .SW    (SEG_SIZE)
        ) uSeg (
            .clk       (clk),
            .rst_n     (rst_n),
            .advance_i (advance),
            .valid_i   (stageValid[s]),
            .carry_i   (stageCarry[s]),
            .aOp_i     (stageA[s]),
            .bOp_i     (stageB[s]),
            .sum_i     (stageSum[s]),
            .valid_o   (stageValid[s+1]),
            .carry_o   (stageCarry[s+1]),
            .aOp_o     (stageA[s+1]),
            .bOp_o     (stageB[s+1]),
            .sum_o     (stageSum[s+1])
        );
    end

    // Results come straight from the last stage registers; overflow compares the
    // effective operand MSBs carried alongside against the result MSB
    assign bus.out_valid = stageValid[NSEG];
    assign bus.sum       = {stageCarry[NSEG], stageSum[NSEG]};
    assign bus.ovf       = (stageA[NSEG][WIDTH-1] == stageB[NSEG][WIDTH-1]) &&
                           (stageSum[NSEG][WIDTH-1] != stageA[NSEG][WIDTH-1]);

endmodule

// File: tb/tb_adder_pipe.sv
// Directed and short streaming checks of adder_pipe in three configurations:
// 120/30 (4 segments), 100/32 (4 segments, 4-bit top), 120/120 (single segment).
module tb_adder_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    int compareCount  = 0;
    int mismatchCount = 0;
    int dutSel = 0;
    string cfgTag = "cfg0";

    logic         drvValid    = 1'b0;
    logic         drvSub      = 1'b0;
    logic         drvCin      = 1'b0;
    logic         drvOutReady = 1'b1;
    logic [119:0] drvA = '0;
    logic [119:0] drvB = '0;

    int cfgW [0:2] = '{120, 100, 120};
    int cfgN [0:2] = '{4, 4, 1};

    adder_pipe_if #(.WIDTH(120)) bus0 ();
    adder_pipe_if #(.WIDTH(100)) bus1 ();
    adder_pipe_if #(.WIDTH(120)) bus2 ();

    adder_pipe #(.WIDTH(120), .SEG_W(30))  dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    adder_pipe #(.WIDTH(100), .SEG_W(32))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    adder_pipe #(.WIDTH(120), .SEG_W(120)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // Only the selected DUT sees beats; idle ones keep draining
    assign bus0.in_valid  = drvValid && (dutSel == 0);
    assign bus0.a         = drvA;
    assign bus0.b         = drvB;
    assign bus0.sub       = drvSub;
    assign bus0.cin       = drvCin;
    assign bus0.out_ready = (dutSel == 0) ? drvOutReady : 1'b1;

    assign bus1.in_valid  = drvValid && (dutSel == 1);
    assign bus1.a         = drvA[99:0];
    assign bus1.b         = drvB[99:0];
    assign bus1.sub       = drvSub;
    assign bus1.cin       = drvCin;
    assign bus1.out_ready = (dutSel == 1) ? drvOutReady : 1'b1;

    assign bus2.in_valid  = drvValid && (dutSel == 2);
    assign bus2.a         = drvA;
    assign bus2.b         = drvB;
    assign bus2.sub       = drvSub;
    assign bus2.cin       = drvCin;
    assign bus2.out_ready = (dutSel == 2) ? drvOutReady : 1'b1;

    logic         obsReady;
    logic         obsValid;
    logic         obsOvf;
    logic [131:0] obsSum;

    // Observation mux for the DUT under test
    always_comb begin
        obsReady = bus0.in_ready;
        obsValid = bus0.out_valid;
        obsOvf   = bus0.ovf;
        obsSum   = 132'(bus0.sum);
        if (dutSel == 1) begin
            obsReady = bus1.in_ready;
            obsValid = bus1.out_valid;
            obsOvf   = bus1.ovf;
            obsSum   = 132'(bus1.sum);
        end else if (dutSel == 2) begin
            obsReady = bus2.in_ready;
            obsValid = bus2.out_valid;
            obsOvf   = bus2.ovf;
            obsSum   = 132'(bus2.sum);
        end
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [131:0] observed, input logic [131:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s/%s: got %0h, expected %0h", cfgTag, tag, observed, expected);
        end
    endtask

    // Reference arithmetic from plain wide integers (unsigned for carry, signed for overflow)
    task automatic refModel(input logic [119:0] a, input logic [119:0] b, input logic sub,
                            input logic cin, input int w,
                            output logic [131:0] expSum, output logic expOvf);
        logic [131:0]        ua, ub, uc, mask, low;
        logic                carry;
        logic signed [131:0] sa, sb, sc, r, lim;
        mask = (132'd1 << w) - 132'd1;
        ua   = 132'(a) & mask;
        ub   = 132'(b) & mask;
        uc   = 132'(cin);
        if (!sub) begin
            expSum = ua + ub + uc;
        end else begin
            carry  = (ua >= ub + uc);
            low    = (ua - ub - uc) & mask;
            expSum = low | (132'(carry) << w);
        end
        sa = $signed(ua);
        if (ua[w-1]) sa = sa - (132'sd1 <<< w);
        sb = $signed(ub);
        if (ub[w-1]) sb = sb - (132'sd1 <<< w);
        sc  = $signed(uc);
        r   = sub ? (sa - sb - sc) : (sa + sb + sc);
        lim = 132'sd1 <<< (w - 1);
        expOvf = (r >= lim) || (r < -lim);
    endtask

    // One beat into an empty pipe: check acceptance, latency, result, then drain
    task automatic applyStimulus(input string tag, input logic [119:0] a, input logic [119:0] b,
                                 input logic sub, input logic cin,
                                 input logic [131:0] expSum, input logic expOvf, input int nseg);
        int lat;
        bit seen;
        drvA = a; drvB = b; drvSub = sub; drvCin = cin;
        drvValid = 1'b1; drvOutReady = 1'b1;
        #1;
        checkOutput({tag, " in_ready"}, 132'(obsReady), 132'd1);
        @(negedge clk);
        drvValid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat <= 20) begin
            #1;
            if (obsValid) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        checkOutput({tag, " latency"}, 132'(lat), 132'(nseg));
        checkOutput({tag, " sum"}, obsSum, expSum);
        checkOutput({tag, " ovf"}, 132'(obsOvf), 132'(expOvf));
        @(negedge clk);
        #1;
        checkOutput({tag, " drained"}, 132'(obsValid), 132'd0);
        @(negedge clk);
    endtask

    // Eight back-to-back beats with the consumer stalled in cycles 3..6
    task automatic runStream(input int w, input int nseg);
        logic [119:0] va [0:7];
        logic [119:0] vb [0:7];
        logic         vs [0:7];
        logic         vc [0:7];
        logic [127:0] tmp;
        logic [131:0] expSumQ [$];
        logic         expOvfQ [$];
        logic [131:0] eSum;
        logic         eOvf;
        int sent = 0;
        int got  = 0;
        for (int i = 0; i < 8; i++) begin
            tmp   = {$urandom(), $urandom(), $urandom(), $urandom()};
            va[i] = tmp[119:0];
            tmp   = {$urandom(), $urandom(), $urandom(), $urandom()};
            vb[i] = tmp[119:0];
            vs[i] = 1'($urandom_range(0, 1));
            vc[i] = 1'($urandom_range(0, 1));
        end
        for (int c = 0; c < 80 && got < 8; c++) begin
            drvOutReady = !(c >= 3 && c <= 6);
            if (sent < 8) begin
                drvA = va[sent]; drvB = vb[sent]; drvSub = vs[sent]; drvCin = vc[sent];
                drvValid = 1'b1;
            end else begin
                drvValid = 1'b0;
            end
            #1;
            if (c >= 3 && c <= 6) begin
                checkOutput($sformatf("stall in_ready c%0d", c), 132'(obsReady),
                            (c >= nseg + 1) ? 132'd0 : 132'd1);
                if (c >= nseg + 1 && expSumQ.size() > 0)
                    checkOutput($sformatf("stall sum hold c%0d", c), obsSum, expSumQ[0]);
            end
            if (obsValid && drvOutReady) begin
                if (expSumQ.size() == 0) begin
                    checkOutput("stream unexpected beat", 132'd1, 132'd0);
                end else begin
                    eSum = expSumQ.pop_front();
                    eOvf = expOvfQ.pop_front();
                    checkOutput($sformatf("stream sum #%0d", got), obsSum, eSum);
                    checkOutput($sformatf("stream ovf #%0d", got), 132'(obsOvf), 132'(eOvf));
                    got++;
                end
            end
            if (drvValid && obsReady) begin
                refModel(va[sent], vb[sent], vs[sent], vc[sent], w, eSum, eOvf);
                expSumQ.push_back(eSum);
                expOvfQ.push_back(eOvf);
                sent++;
            end
            @(negedge clk);
        end
        drvValid = 1'b0;
        drvOutReady = 1'b1;
        checkOutput("stream beats out", 132'(got), 132'd8);
        checkOutput("stream leftover", 132'(expSumQ.size()), 132'd0);
        repeat (nseg + 2) @(negedge clk);
        #1;
        checkOutput("stream no duplicate", 132'(obsValid), 132'd0);
        @(negedge clk);
    endtask

    // Three beats in flight, then an asynchronous reset pulse
    task automatic runResetMid(input int nseg);
        drvOutReady = 1'b1;
        drvSub = 1'b0;
        drvCin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drvA = 120'(i + 1);
            drvB = 120'(100 * (i + 1));
            drvValid = 1'b1;
            @(negedge clk);
        end
        drvValid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("reset out_valid", 132'(obsValid), 132'd0);
        checkOutput("reset sum", obsSum, 132'd0);
        checkOutput("reset ovf", 132'(obsOvf), 132'd0);
        checkOutput("reset in_ready", 132'(obsReady), 132'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("post-reset beat", 120'h1234, 120'h4321, 1'b0, 1'b1, 132'h5556, 1'b0, nseg);
    endtask

    logic [119:0] allOnes;
    logic [119:0] one;

    initial begin
        int w;
        int n;
        allOnes = '1;
        one     = 120'd1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            dutSel = k;
            cfgTag = $sformatf("cfg%0d", k);
            #1;
            checkOutput("in reset out_valid", 132'(obsValid), 132'd0);
            checkOutput("in reset sum", obsSum, 132'd0);
            checkOutput("in reset in_ready", 132'(obsReady), 132'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            dutSel = k;
            cfgTag = $sformatf("cfg%0d", k);
            w = cfgW[k];
            n = cfgN[k];
            @(negedge clk);
            #1;
            checkOutput("idle out_valid", 132'(obsValid), 132'd0);
            checkOutput("idle sum", obsSum, 132'd0);
            checkOutput("idle ovf", 132'(obsOvf), 132'd0);
            checkOutput("idle in_ready", 132'(obsReady), 132'd1);
            @(negedge clk);
            applyStimulus("add carry ripple", allOnes >> (120 - w), 120'd1, 1'b0, 1'b0,
                          132'd1 << w, 1'b0, n);
            applyStimulus("sub 5-7", 120'd5, 120'd7, 1'b1, 1'b0,
                          (132'd1 << w) - 132'd2, 1'b0, n);
            applyStimulus("sub 7-5-1", 120'd7, 120'd5, 1'b1, 1'b1,
                          (132'd1 << w) | 132'd1, 1'b0, n);
            applyStimulus("add signed ovf", (one << (w - 1)) - 120'd1, 120'd1, 1'b0, 1'b0,
                          132'd1 << (w - 1), 1'b1, n);
            applyStimulus("sub signed ovf", one << (w - 1), 120'd1, 1'b1, 1'b0,
                          (132'd1 << w) | ((132'd1 << (w - 1)) - 132'd1), 1'b1, n);
            runStream(w, n);
            runResetMid(n);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 Parameter WIDTH, default 120: operand width in bits, minimum 2.
REQ-002 Parameter SEG_W, default 30: bits per carry segment, 1 to WIDTH; NSEG = ceil(WIDTH/SEG_W).
REQ-003 Port clk  input  1: sole clock, all state on rising edge.
REQ-004 Port rst_n  input  1: asynchronous, active-low reset.
REQ-005 Port in_valid  input  1: operand beat present.
REQ-006 Port in_ready  output  1: block accepts a beat this cycle.
REQ-007 Port a, b  input  WIDTH each: operands.
REQ-008 Port sub  input  1: 0 = add, 1 = subtract.
REQ-009 Port cin  input  1: carry-in (add) or borrow-in (subtract).
REQ-010 Port out_valid  output  1: result present.
REQ-011 Port out_ready  input  1: consumer takes the result this cycle.
REQ-012 Port sum  output  WIDTH+1: result; bit WIDTH is carry-out.
REQ-013 Port ovf  output  1: two's-complement signed overflow of sum[WIDTH-1:0].

Function
REQ-014 A beat is accepted on a rising edge when in_valid and in_ready are both 1.
REQ-015 Add mode computes a + b + cin; subtract mode computes a + ~b + !cin, i.e. a - b - cin.
REQ-016 sum[WIDTH] is the raw carry-out; in subtract mode 1 means no borrow.
REQ-017 ovf = 1 when the effective operands a and (sub ? ~b : b) have equal MSBs and sum[WIDTH-1] differs from them.
REQ-018 Addition is split into NSEG segments; one segment resolves per stage; carry between segments is registered.
REQ-019 Stage 0 registers the operands; stage k (k = 1..NSEG) adds segment k-1.
REQ-020 Operand segments not yet consumed are skew-delayed and completed result segments are de-skewed so every output bit belongs to the same beat.
REQ-021 The last segment has width WIDTH - (NSEG-1)*SEG_W when WIDTH is not a multiple of SEG_W.
REQ-022 Latency is NSEG cycles: a beat accepted at edge E appears with out_valid=1 after edge E+NSEG if no stall occurs.
REQ-023 Throughput is one beat per cycle with no bubbles when out_ready is held at 1.
REQ-024 Each stage carries a valid bit; bubbles propagate as valid=0.
REQ-025 Global advance = !out_valid | out_ready; in_ready = advance; all stages hold when advance = 0.
REQ-026 When the pipeline holds, sum, ovf and out_valid are stable, and no beat is lost, duplicated or reordered.
REQ-027 When in_valid=1 and in_ready=0, the beat is not accepted; the producer must hold it until accepted.
REQ-028 When out_ready=1 and in_valid=1 occur together with a full pipe, the output is consumed and the input is accepted on the same edge.

Reset
REQ-029 While rst_n = 0: all stage valid bits = 0; out_valid = 0; sum = 0; ovf = 0; all carry registers = 0.
REQ-030 in_ready is 1 during and after reset, since out_valid = 0.
REQ-031 Reset asserted mid-operation discards all in-flight beats immediately (asynchronously); none reappear after rst_n rises.
REQ-032 The first edge after rst_n rises may accept a beat.

Structure
REQ-033 Package adder_pipe_pkg holds a function computing NSEG and last-segment width from WIDTH and SEG_W, plus default parameter constants.
REQ-034 Sub-module adder_seg implements one segment stage: segment adder, registered carry-out, valid bit and hold enable; adder_pipe instantiates NSEG of them with a generate loop.
REQ-035 No vendor primitives; all arithmetic is inferred.

Verification
REQ-036 Reset then idle -> out_valid=0, sum=0, ovf=0, in_ready=1.
REQ-037 Add a=2^120-1, b=1, cin=0 -> after 4 cycles sum=2^120 (bit 120=1, rest 0), ovf=0; carry ripples through all 4 segments.
REQ-038 Subtract a=5, b=7, cin=0 -> sum[119:0]=2^120-2, sum[120]=0, ovf=0; add a=2^119-1, b=1 -> ovf=1.
REQ-039 Stream 8 back-to-back random beats with out_ready low for cycles 3-6 -> in_ready=0 during the stall; outputs match a reference model in order, with no loss or duplication.
REQ-040 Drive rst_n low for 1 cycle with 3 beats in flight -> out_valid drops immediately; the next beat after release emerges alone at latency 4.
REQ-041 Rerun REQ-037 to REQ-039 with WIDTH=100, SEG_W=32 (NSEG=4, last segment 4 bits) and with SEG_W=WIDTH (NSEG=1, latency 1) -> results exact.
